// File: rtl/rename_stage_pkg.sv
// rename_stage_pkg
// Shared sizes, tag types and the per-slot rename result struct for the
// 2-wide rename stage and its free list.
// Contents:
//   ARCH_REGS / PHY_REGS / PHY_WIDTH / FL_DEPTH  machine sizes
//   phy_tag_t, arch_reg_t, fl_idx_t, fl_ptr_t    tag and pointer types
//   rename_out_t                                 one renamed slot
//   pop_count2()                                 ones-count of a 2-bit vector
package rename_stage_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int PHY_REGS   = 64;
  localparam int PHY_WIDTH  = 6;
  localparam int ARCH_WIDTH = 5;
  localparam int FL_DEPTH   = PHY_REGS - ARCH_REGS;
  localparam int FL_IDX_W   = 5;

  typedef logic [PHY_WIDTH-1:0]  phy_tag_t;
  typedef logic [ARCH_WIDTH-1:0] arch_reg_t;
  typedef logic [FL_IDX_W-1:0]   fl_idx_t;
  // Free-list pointers carry one extra wrap bit so full and empty differ.
  typedef logic [FL_IDX_W:0]     fl_ptr_t;

  typedef struct packed {
    phy_tag_t prs1;
    phy_tag_t prs2;
    phy_tag_t prd;
    phy_tag_t old_prd;
    logic     rd_we;
  } rename_out_t;

  function automatic logic [1:0] pop_count2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rename_stage_if.sv
// rename_stage_if
// Bundles the decode-side, dispatch-side and commit-side signals of the
// rename stage. The pipeline environment uses modport master, the rename
// stage uses modport slave.
//   decode   : dec_valid, dec_rs1/rs2/rd/rd_we per slot, rename_ready
//   dispatch : dispatch_stall, ren_valid, ren_prs1/prs2/prd/old_prd, ren_rd_we
//   commit   : commit_valid, commit_rd_we, commit_rd/prd/old_prd per slot
//   control  : flush
// Optional macro RENAME_PERF_EN adds perf_fl_stall_cycles.
interface rename_stage_if;
  import rename_stage_pkg::*;

  logic       flush;

  logic [1:0] dec_valid;
  arch_reg_t  dec_rs1_0, dec_rs2_0, dec_rd_0;
  logic       dec_rd_we_0;
  arch_reg_t  dec_rs1_1, dec_rs2_1, dec_rd_1;
  logic       dec_rd_we_1;
  logic       rename_ready;

  logic       dispatch_stall;
  logic [1:0] ren_valid;
  phy_tag_t   ren_prs1_0, ren_prs2_0, ren_prd_0, ren_old_prd_0;
  phy_tag_t   ren_prs1_1, ren_prs2_1, ren_prd_1, ren_old_prd_1;
  logic [1:0] ren_rd_we;

  logic [1:0] commit_valid;
  logic [1:0] commit_rd_we;
  arch_reg_t  commit_rd_0, commit_rd_1;
  phy_tag_t   commit_prd_0, commit_prd_1;
  phy_tag_t   commit_old_prd_0, commit_old_prd_1;

`ifdef RENAME_PERF_EN
  logic [31:0] perf_fl_stall_cycles;
`endif

  modport master (
    output flush,
    output dec_valid, dec_rs1_0, dec_rs2_0, dec_rd_0, dec_rd_we_0,
    output dec_rs1_1, dec_rs2_1, dec_rd_1, dec_rd_we_1,
    input  rename_ready,
    output dispatch_stall,
    input  ren_valid, ren_prs1_0, ren_prs2_0, ren_prd_0, ren_old_prd_0,
    input  ren_prs1_1, ren_prs2_1, ren_prd_1, ren_old_prd_1, ren_rd_we,
    output commit_valid, commit_rd_we, commit_rd_0, commit_rd_1,
    output commit_prd_0, commit_prd_1, commit_old_prd_0, commit_old_prd_1
`ifdef RENAME_PERF_EN
    , input perf_fl_stall_cycles
`endif
  );

  modport slave (
    input  flush,
    input  dec_valid, dec_rs1_0, dec_rs2_0, dec_rd_0, dec_rd_we_0,
    input  dec_rs1_1, dec_rs2_1, dec_rd_1, dec_rd_we_1,
    output rename_ready,
    input  dispatch_stall,
    output ren_valid, ren_prs1_0, ren_prs2_0, ren_prd_0, ren_old_prd_0,
    output ren_prs1_1, ren_prs2_1, ren_prd_1, ren_old_prd_1, ren_rd_we,
    input  commit_valid, commit_rd_we, commit_rd_0, commit_rd_1,
    input  commit_prd_0, commit_prd_1, commit_old_prd_0, commit_old_prd_1
`ifdef RENAME_PERF_EN
    , output perf_fl_stall_cycles
`endif
  );

endinterface

// File: rtl/rename_stage_free_list.sv
// rename_free_list
// Circular FIFO of free physical tags with up to two pops and two pushes per
// cycle, plus a commit head that is restored into the speculative head on
// flush.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   pop_cnt     number of tags consumed this cycle (0..2)
//   pop_tag     fl[head], fl[head+1]
//   push_valid  per commit slot, return a tag (in order, slot0 first)
//   push_tag    tags returned by commit slots 0/1
//   restore     move head back to the commit head (same-cycle pushes included)
//   free_count  tail - head, 0..FL_DEPTH
module rename_free_list
  import rename_stage_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                pop_cnt,
  output logic [1:0][PHY_WIDTH-1:0] pop_tag,
  input  logic [1:0]                push_valid,
  input  logic [1:0][PHY_WIDTH-1:0] push_tag,
  input  logic                      restore,
  output fl_ptr_t                   free_count
);

  phy_tag_t fl_q [FL_DEPTH];
  fl_ptr_t  head_q, tail_q, commit_head_q;
  fl_ptr_t  push_cnt;
  fl_idx_t  head_idx1, tail_idx1;

  // Every push retires one allocation, so tail and commit head always move
  // together; a push therefore only ever overwrites the slot the commit head
  // just left, never a speculatively popped entry that a restore may reuse.
  always_comb begin
    push_cnt  = fl_ptr_t'(pop_count2(push_valid));
    head_idx1 = head_q[FL_IDX_W-1:0] + fl_idx_t'(1);
    tail_idx1 = tail_q[FL_IDX_W-1:0] + fl_idx_t'(push_valid[0]);
  end

  assign pop_tag[0] = fl_q[head_q[FL_IDX_W-1:0]];
  assign pop_tag[1] = fl_q[head_idx1];
  assign free_count = tail_q - head_q;

  // Reset leaves the list full (tail one lap ahead of head) with tags
  // ARCH_REGS..PHY_REGS-1 in ascending order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= PHY_WIDTH'(ARCH_REGS + i);
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= fl_ptr_t'(FL_DEPTH);
    end else begin
      if (push_valid[0]) fl_q[tail_q[FL_IDX_W-1:0]] <= push_tag[0];
      if (push_valid[1]) fl_q[tail_idx1]            <= push_tag[1];
      tail_q        <= tail_q + push_cnt;
      commit_head_q <= commit_head_q + push_cnt;
      head_q        <= restore ? (commit_head_q + push_cnt)
                               : (head_q + fl_ptr_t'(pop_cnt));
    end
  end

endmodule

// File: rtl/rename_stage.sv
// rename_stage
// 2-wide register rename ahead of dispatch: speculative RAT lookup, free-list
// allocation, intra-group bypass, registered output pair, committed RAT and
// flush recovery.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       rename_stage_if.slave (decode, dispatch, commit, flush)
// Optional macro RENAME_PERF_EN: bus.perf_fl_stall_cycles counts cycles a
// valid group waits only because the free list is short.
module rename_stage
  import rename_stage_pkg::*;
(
  input logic           clk,
  input logic           rst,
  rename_stage_if.slave bus
);

  phy_tag_t spec_rat_q   [ARCH_REGS];
  phy_tag_t commit_rat_q [ARCH_REGS];
  phy_tag_t commit_rat_d [ARCH_REGS];

  logic [1:0]                alloc, need, pop_cnt, push_valid;
  logic [1:0][PHY_WIDTH-1:0] pop_tag, push_tag;
  fl_ptr_t                   free_count;
  logic                      enough, ready;
  rename_out_t               slot0_d, slot1_d, slot0_q, slot1_q;
  logic [1:0]                valid_q;

  // Acceptance is all-or-nothing: the group waits unless every writer can
  // get a tag.
  always_comb begin
    alloc[0] = bus.dec_valid[0] & bus.dec_rd_we_0 & (bus.dec_rd_0 != '0);
    alloc[1] = bus.dec_valid[1] & bus.dec_rd_we_1 & (bus.dec_rd_1 != '0);
    need     = pop_count2(alloc);
    enough   = free_count >= fl_ptr_t'(need);
    ready    = !rst & !bus.flush & !bus.dispatch_stall & enough;
    pop_cnt  = ready ? need : 2'd0;
  end

  assign bus.rename_ready = ready;

  always_comb begin
    push_valid[0] = bus.commit_valid[0] & bus.commit_rd_we[0] & (bus.commit_rd_0 != '0);
    push_valid[1] = bus.commit_valid[1] & bus.commit_rd_we[1] & (bus.commit_rd_1 != '0);
    push_tag[0]   = bus.commit_old_prd_0;
    push_tag[1]   = bus.commit_old_prd_1;
  end

  rename_free_list u_free_list (
    .clk        (clk),
    .rst        (rst),
    .pop_cnt    (pop_cnt),
    .pop_tag    (pop_tag),
    .push_valid (push_valid),
    .push_tag   (push_tag),
    .restore    (bus.flush),
    .free_count (free_count)
  );

  // RAT entry 0 is never written (writers of x0 do not allocate), so a plain
  // lookup of x0 always yields tag 0. Slot1 sees slot0's new tag for any
  // source or destination that matches slot0's allocating rd.
  always_comb begin
    slot0_d         = '0;
    slot0_d.prs1    = spec_rat_q[bus.dec_rs1_0];
    slot0_d.prs2    = spec_rat_q[bus.dec_rs2_0];
    slot0_d.rd_we   = alloc[0];
    if (alloc[0]) begin
      slot0_d.prd     = pop_tag[0];
      slot0_d.old_prd = spec_rat_q[bus.dec_rd_0];
    end

    slot1_d         = '0;
    slot1_d.prs1    = (alloc[0] && bus.dec_rs1_1 == bus.dec_rd_0) ? slot0_d.prd
                                                                  : spec_rat_q[bus.dec_rs1_1];
    slot1_d.prs2    = (alloc[0] && bus.dec_rs2_1 == bus.dec_rd_0) ? slot0_d.prd
                                                                  : spec_rat_q[bus.dec_rs2_1];
    slot1_d.rd_we   = alloc[1];
    if (alloc[1]) begin
      slot1_d.prd     = alloc[0] ? pop_tag[1] : pop_tag[0];
      slot1_d.old_prd = (alloc[0] && bus.dec_rd_1 == bus.dec_rd_0) ? slot0_d.prd
                                                                   : spec_rat_q[bus.dec_rd_1];
    end
  end

  // Committed RAT including this cycle's retirements; slot1 written last so
  // it wins on a shared rd. A flush copies this value into the spec RAT.
  always_comb begin
    commit_rat_d = commit_rat_q;
    if (push_valid[0]) commit_rat_d[bus.commit_rd_0] = bus.commit_prd_0;
    if (push_valid[1]) commit_rat_d[bus.commit_rd_1] = bus.commit_prd_1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        commit_rat_q[i] <= PHY_WIDTH'(i);
      end
    end else begin
      commit_rat_q <= commit_rat_d;
    end
  end

  // Same-rd pairs: both non-blocking writes land, the later (slot1) wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat_q[i] <= PHY_WIDTH'(i);
      end
    end else if (bus.flush) begin
      spec_rat_q <= commit_rat_d;
    end else if (ready) begin
      if (alloc[0]) spec_rat_q[bus.dec_rd_0] <= slot0_d.prd;
      if (alloc[1]) spec_rat_q[bus.dec_rd_1] <= slot1_d.prd;
    end
  end

  // Flush beats stall; a stall freezes the pair; otherwise an idle cycle
  // empties the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (!bus.dispatch_stall) begin
      if (ready) begin
        valid_q <= bus.dec_valid;
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
      end else begin
        valid_q <= '0;
      end
    end
  end

  assign bus.ren_valid     = valid_q;
  assign bus.ren_prs1_0    = slot0_q.prs1;
  assign bus.ren_prs2_0    = slot0_q.prs2;
  assign bus.ren_prd_0     = slot0_q.prd;
  assign bus.ren_old_prd_0 = slot0_q.old_prd;
  assign bus.ren_prs1_1    = slot1_q.prs1;
  assign bus.ren_prs2_1    = slot1_q.prs2;
  assign bus.ren_prd_1     = slot1_q.prd;
  assign bus.ren_old_prd_1 = slot1_q.old_prd;
  assign bus.ren_rd_we     = valid_q & {slot1_q.rd_we, slot0_q.rd_we};

`ifdef RENAME_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of cycles a group is blocked purely by free-list space.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if ((bus.dec_valid != 2'b00) && !bus.dispatch_stall && !enough
                 && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_fl_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage
// Randomized bench for rename_stage with a reference model built from
// architectural rules: a RAT array per view, a queue of free tags, a queue of
// in-flight allocations and an in-order list of renamed instructions.
module tb_rename_stage;
  import rename_stage_pkg::*;

  typedef struct {
    bit          we;
    bit          alloc;
    int unsigned rd;
    int unsigned prd;
    int unsigned old;
  } rob_t;

  logic clk = 1'b0;
  logic rst;

  rename_stage_if bus();

  rename_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus for the current cycle
  bit [1:0]    d_valid;
  int unsigned d_rs1[2], d_rs2[2], d_rd[2];
  bit          d_we[2];
  bit          d_flush, d_stall, d_rst;
  int          c_n;
  rob_t        c_ent[2];

  // reference model
  int unsigned srat[32], crat[32];
  int unsigned freeq[$], inflight[$];
  rob_t        rob[$];
  bit [1:0]    e_valid;
  int unsigned e_prs1[2], e_prs2[2], e_prd[2], e_old[2];
  bit          e_we[2];
  int unsigned perf_m;
  bit          last_acc, last_flush, last_rst;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    rst                  = d_rst;
    bus.flush            = d_flush;
    bus.dispatch_stall   = d_stall;
    bus.dec_valid        = d_valid;
    bus.dec_rs1_0        = 5'(d_rs1[0]);
    bus.dec_rs2_0        = 5'(d_rs2[0]);
    bus.dec_rd_0         = 5'(d_rd[0]);
    bus.dec_rd_we_0      = d_we[0];
    bus.dec_rs1_1        = 5'(d_rs1[1]);
    bus.dec_rs2_1        = 5'(d_rs2[1]);
    bus.dec_rd_1         = 5'(d_rd[1]);
    bus.dec_rd_we_1      = d_we[1];
    bus.commit_valid     = (c_n == 2) ? 2'b11 : (c_n == 1) ? 2'b01 : 2'b00;
    bus.commit_rd_we[0]  = (c_n >= 1) && c_ent[0].we;
    bus.commit_rd_we[1]  = (c_n == 2) && c_ent[1].we;
    bus.commit_rd_0      = 5'(c_ent[0].rd);
    bus.commit_rd_1      = 5'(c_ent[1].rd);
    bus.commit_prd_0     = 6'(c_ent[0].prd);
    bus.commit_prd_1     = 6'(c_ent[1].prd);
    bus.commit_old_prd_0 = 6'(c_ent[0].old);
    bus.commit_old_prd_1 = 6'(c_ent[1].old);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      srat[i] = i;
      crat[i] = i;
    end
    freeq.delete();
    for (int i = 0; i < 32; i++) freeq.push_back(32 + i);
    inflight.delete();
    rob.delete();
    e_valid = 2'b00;
    for (int s = 0; s < 2; s++) begin
      e_prs1[s] = 0; e_prs2[s] = 0; e_prd[s] = 0; e_old[s] = 0; e_we[s] = 0;
    end
    perf_m = 0;
  endtask

  task automatic check_slot(input int s, input logic [5:0] p1, input logic [5:0] p2,
                            input logic [5:0] pd, input logic [5:0] po, input logic we);
    checkOutput($sformatf("prs1_%0d", s), p1, e_prs1[s]);
    checkOutput($sformatf("prs2_%0d", s), p2, e_prs2[s]);
    checkOutput($sformatf("prd_%0d", s), pd, e_prd[s]);
    checkOutput($sformatf("rd_we_%0d", s), we, e_we[s]);
    if (e_we[s]) checkOutput($sformatf("old_prd_%0d", s), po, e_old[s]);
  endtask

  // One clock: check outputs at the falling edge, advance the model, then
  // move to just after the next rising edge.
  task automatic run_cycle();
    int          need;
    bit          m_ready;
    int unsigned n_prs1[2], n_prs2[2], n_prd[2], n_old[2];
    bit          n_we[2];
    rob_t        ent;
    @(negedge clk);
    need = 0;
    for (int s = 0; s < 2; s++)
      if (d_valid[s] && d_we[s] && d_rd[s] != 0) need++;
    m_ready = !d_rst && !d_flush && !d_stall && (freeq.size() >= need);
    checkOutput(d_rst ? "ready_in_reset" : "rename_ready", bus.rename_ready, m_ready);
    checkOutput("ren_valid", bus.ren_valid, e_valid);
    if (e_valid[0]) check_slot(0, bus.ren_prs1_0, bus.ren_prs2_0, bus.ren_prd_0,
                               bus.ren_old_prd_0, bus.ren_rd_we[0]);
    if (e_valid[1]) check_slot(1, bus.ren_prs1_1, bus.ren_prs2_1, bus.ren_prd_1,
                               bus.ren_old_prd_1, bus.ren_rd_we[1]);
`ifdef RENAME_PERF_EN
    checkOutput("perf_fl_stall", bus.perf_fl_stall_cycles, perf_m);
`endif
    if (d_rst) begin
      model_reset();
    end else begin
      if (d_valid != 0 && !d_stall && freeq.size() < need && perf_m != 32'hFFFF_FFFF)
        perf_m++;
      for (int s = 0; s < 2; s++) begin
        n_prs1[s] = 0; n_prs2[s] = 0; n_prd[s] = 0; n_old[s] = 0; n_we[s] = 0;
      end
      if (m_ready) begin
        // sequential semantics: slot1 sees slot0's effect on the map
        for (int s = 0; s < 2; s++) begin
          if (d_valid[s]) begin
            n_prs1[s] = (d_rs1[s] == 0) ? 0 : srat[d_rs1[s]];
            n_prs2[s] = (d_rs2[s] == 0) ? 0 : srat[d_rs2[s]];
            n_we[s]   = d_we[s] && d_rd[s] != 0;
            if (n_we[s]) begin
              n_old[s] = srat[d_rd[s]];
              n_prd[s] = freeq.pop_front();
              inflight.push_back(n_prd[s]);
              srat[d_rd[s]] = n_prd[s];
            end
            rob.push_back('{d_we[s], n_we[s], d_rd[s], n_prd[s], n_old[s]});
          end
        end
      end
      for (int k = 0; k < c_n; k++) begin
        ent = rob.pop_front();
        if (ent.alloc) begin
          crat[ent.rd] = ent.prd;
          void'(inflight.pop_front());
          freeq.push_back(ent.old);
        end
      end
      if (d_flush) begin
        srat = crat;
        for (int k = inflight.size() - 1; k >= 0; k--) freeq.push_front(inflight[k]);
        inflight.delete();
        rob.delete();
        e_valid = 2'b00;
      end else if (!d_stall) begin
        if (m_ready) begin
          e_valid = d_valid;
          for (int s = 0; s < 2; s++) begin
            e_prs1[s] = n_prs1[s]; e_prs2[s] = n_prs2[s];
            e_prd[s]  = n_prd[s];  e_old[s]  = n_old[s]; e_we[s] = n_we[s];
          end
        end else begin
          e_valid = 2'b00;
        end
      end
    end
    last_acc   = m_ready;
    last_flush = d_flush;
    last_rst   = d_rst;
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned rand_reg();
    return ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
  endfunction

  task automatic clear_commit();
    c_n = 0;
    for (int k = 0; k < 2; k++) c_ent[k] = '{0, 0, 0, 0, 0};
  endtask

  task automatic set_group(input bit [1:0] v,
                           input int unsigned a1, input int unsigned a2, input int unsigned ad, input bit aw,
                           input int unsigned b1, input int unsigned b2, input int unsigned bd, input bit bw);
    d_rst = 0; d_flush = 0; d_stall = 0;
    d_valid = v;
    d_rs1[0] = a1; d_rs2[0] = a2; d_rd[0] = ad; d_we[0] = aw;
    d_rs1[1] = b1; d_rs2[1] = b2; d_rd[1] = bd; d_we[1] = bw;
    clear_commit();
  endtask

  task automatic do_reset();
    set_group(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    d_rst = 1;
    applyStimulus();
    run_cycle();
    d_rst = 0;
  endtask

  // A group not yet accepted is held, as upstream must do.
  task automatic gen_cycle(input int commit_pct, input int flush_pct,
                           input int stall_pct, input bit dense);
    int avail;
    d_rst = 0;
    if (last_acc || last_flush || last_rst) begin
      d_valid = dense ? 2'b11 : 2'($urandom_range(0, 3));
      for (int s = 0; s < 2; s++) begin
        d_rs1[s] = rand_reg();
        d_rs2[s] = rand_reg();
        d_rd[s]  = dense ? $urandom_range(1, 31) : rand_reg();
        d_we[s]  = dense ? 1'b1 : ($urandom_range(0, 7) != 0);
      end
    end
    d_flush = ($urandom_range(0, 99) < flush_pct);
    d_stall = ($urandom_range(0, 99) < stall_pct);
    clear_commit();
    avail = (rob.size() < 2) ? rob.size() : 2;
    if (avail > 0 && $urandom_range(0, 99) < commit_pct) begin
      c_n = $urandom_range(1, avail);
      for (int k = 0; k < c_n; k++) c_ent[k] = rob[k];
    end
    applyStimulus();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    model_reset();
    last_acc = 0; last_flush = 0; last_rst = 1;
    set_group(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    d_rst = 1;
    applyStimulus();
    @(posedge clk);
    #1;
    run_cycle();
    d_rst = 0;

    // add x1,x2,x3 after reset
    set_group(2'b01, 2, 3, 1, 1, 0, 0, 0, 0);
    applyStimulus();
    run_cycle();
    checkOutput("t1_valid", bus.ren_valid, 2'b01);
    checkOutput("t1_prs1", bus.ren_prs1_0, 2);
    checkOutput("t1_prs2", bus.ren_prs2_0, 3);
    checkOutput("t1_prd", bus.ren_prd_0, 32);
    checkOutput("t1_old", bus.ren_old_prd_0, 1);

    // same rd in both slots, slot1 reads slot0's rd
    do_reset();
    set_group(2'b11, 0, 0, 5, 1, 5, 0, 5, 1);
    applyStimulus();
    run_cycle();
    checkOutput("t2_prd0", bus.ren_prd_0, 32);
    checkOutput("t2_prs1_1", bus.ren_prs1_1, 32);
    checkOutput("t2_old1", bus.ren_old_prd_1, 32);
    checkOutput("t2_prd1", bus.ren_prd_1, 33);
    set_group(2'b01, 5, 5, 0, 0, 0, 0, 0, 0);
    applyStimulus();
    run_cycle();
    checkOutput("t2_rat5", bus.ren_prs1_0, 33);

    // exhaust the free list, then free tag 7
    do_reset();
    for (int g = 0; g < 16; g++) begin
      set_group(2'b11, rand_reg(), rand_reg(), (g == 0) ? 7 : $urandom_range(1, 31), 1,
                rand_reg(), rand_reg(), $urandom_range(1, 31), 1);
      applyStimulus();
      run_cycle();
    end
    set_group(2'b01, 1, 2, 9, 1, 0, 0, 0, 0);
    applyStimulus();
    #1;
    checkOutput("t3_full_ready", bus.rename_ready, 0);
    run_cycle();
    c_n = 1;
    c_ent[0] = rob[0];
    applyStimulus();
    #1;
    checkOutput("t3_commit_ready", bus.rename_ready, 0);
    run_cycle();
    clear_commit();
    applyStimulus();
    #1;
    checkOutput("t3_freed_ready", bus.rename_ready, 1);
    run_cycle();
    checkOutput("t3_prd", bus.ren_prd_0, 7);

    // rd = x0 with rd_we: no allocation
    set_group(2'b01, 1, 2, 0, 1, 0, 0, 0, 0);
    applyStimulus();
    run_cycle();
    checkOutput("t6_valid", bus.ren_valid, 2'b01);
    checkOutput("t6_prd", bus.ren_prd_0, 0);
    checkOutput("t6_rd_we", bus.ren_rd_we, 2'b00);

    // randomized traffic with a mid-run reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        do_reset();
      end else begin
        gen_cycle(60, 4, 20, 1'b0);
        run_cycle();
      end
    end
    for (int i = 0; i < 60; i++) begin
      gen_cycle(0, 0, 10, 1'b1);
      run_cycle();
    end
    for (int i = 0; i < 300; i++) begin
      gen_cycle(70, 5, 20, 1'b0);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
